// File: rtl/wb_cmd_master_if.sv
// Command/response and Wishbone B4 pipelined bus bundle for wb_cmd_master.
interface wb_cmd_master_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_adr_i;
    logic [31:0]       cmd_dat_i;
    logic [3:0]        cmd_sel_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_dat_o;
    logic [1:0]        rsp_status_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;
    logic              wb_stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone B4 command master.
// Optional bus timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic             clk_i,
    input logic             rst_i,
    wb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              rdy_q, rdy_d;
    logic              rv_q, rv_d;
    logic [31:0]       rdat_q, rdat_d;
    logic [1:0]        st_q, st_d;
    logic              term, done, to_hit, tmo;

    assign term = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        to_hit = 1'b0;
        if (cyc_q) begin
            cnt_d  = cnt_q + 16'd1;
            to_hit = (cnt_q == 16'(TIMEOUT - 1));
        end
        if (state_q == IDLE && bus.cmd_valid_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    // never fires: TIMEOUT is at least 1
    assign to_hit = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdy_d   = rdy_q;
        rv_d    = 1'b0;
        rdat_d  = rdat_q;
        st_d    = st_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    we_d    = bus.cmd_we_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!bus.wb_stall_i) begin
                    if (term) begin
                        done = 1'b1;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: done = term;
            default: state_d = IDLE;
        endcase
        // a real termination on the deadline cycle beats the timeout
        tmo = to_hit & ~done;
        if (done) begin
            if (bus.wb_err_i)      st_d = 2'b01;
            else if (bus.wb_rty_i) st_d = 2'b10;
            else                   st_d = 2'b00;
            if (bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i && !we_q)
                rdat_d = bus.wb_dat_i;
            else
                rdat_d = '0;
        end
        if (tmo) begin
            st_d   = 2'b11;
            rdat_d = '0;
        end
        if (done || tmo) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            rv_d    = 1'b1;
            rdy_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdy_q   <= 1'b1;
            rv_q    <= 1'b0;
            rdat_q  <= '0;
            st_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdy_q   <= rdy_d;
            rv_q    <= rv_d;
            rdat_q  <= rdat_d;
            st_q    <= st_d;
        end
    end

    assign bus.cmd_ready_o  = rdy_q;
    assign bus.rsp_valid_o  = rv_q;
    assign bus.rsp_dat_o    = rdat_q;
    assign bus.rsp_status_o = st_q;
    assign bus.wb_cyc_o     = cyc_q;
    assign bus.wb_stb_o     = stb_q;
    assign bus.wb_we_o      = we_q;
    assign bus.wb_adr_o     = adr_q;
    assign bus.wb_sel_o     = sel_q;
    assign bus.wb_dat_o     = dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized self-checking bench for wb_cmd_master.
// Covers both builds of WB_CMD_MASTER_TIMEOUT_EN.
module tb_wb_cmd_master;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc_n  = 0;
    int   last_rsp_cyc;
    logic [31:0] last_rd;
    logic [1:0]  last_st;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_cmd_master_if #(.ADDR_W(32)) bus ();

    wb_cmd_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic quiet_slave();
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        bus.wb_rty_i   = 1'b0;
        bus.wb_stall_i = 1'b0;
        bus.wb_dat_i   = $urandom;
    endtask

    // Reference rules: err beats rty beats ack; data only on a clean read ack.
    function automatic logic [1:0] ref_st(input logic [2:0] t);
        if (t[2])      return 2'b01;
        else if (t[1]) return 2'b10;
        else           return 2'b00;
    endfunction

    function automatic logic [31:0] ref_dat(input logic we, input logic [2:0] t,
                                            input logic [31:0] rd);
        return (!we && t == 3'b001) ? rd : 32'h0;
    endfunction

    // t = {err, rty, ack}; called and returns on a negedge with the DUT idle
    task automatic run_txn(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int nstall, input int nwait,
                           input logic [2:0] t, input logic [31:0] rd,
                           input logic hold);
        logic [1:0]  est;
        logic [31:0] ed;
        chk("ready_idle", bus.cmd_ready_o, 1'b1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = hold;
        bus.cmd_we_i    = $urandom;
        bus.cmd_adr_i   = $urandom;
        bus.cmd_dat_i   = $urandom;
        bus.cmd_sel_i   = $urandom;
        for (int c = 0; c <= nstall + nwait; c++) begin
            chk("bus_hold",
                {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
                 bus.wb_adr_o, bus.wb_dat_o, bus.cmd_ready_o, bus.rsp_valid_o},
                {1'b1, 1'(c <= nstall), we, sel, adr, dat, 1'b0, 1'b0});
            if (c == 0)
                chk("rsp_hold", {bus.rsp_status_o, bus.rsp_dat_o},
                    {last_st, last_rd});
            quiet_slave();
            if (c < nstall) begin
                bus.wb_stall_i = 1'b1;
                {bus.wb_err_i, bus.wb_rty_i, bus.wb_ack_i} = 3'($urandom);
            end else if (c == nstall + nwait) begin
                {bus.wb_err_i, bus.wb_rty_i, bus.wb_ack_i} = t;
                bus.wb_dat_i = rd;
            end
            @(posedge clk);
            @(negedge clk);
        end
        quiet_slave();
        bus.cmd_valid_i = 1'b0;
        est = ref_st(t);
        ed  = ref_dat(we, t, rd);
        chk("rsp",
            {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.cmd_ready_o,
             bus.rsp_status_o, bus.rsp_dat_o},
            {1'b0, 1'b0, 1'b1, 1'b1, est, ed});
        last_st      = est;
        last_rd      = ed;
        last_rsp_cyc = cyc_n;
    endtask

    initial begin
        int prev;
        int cnt;
        rst = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        quiet_slave();
        #1 rst = 1'b1;
        #1;
        chk("rst_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                        bus.rsp_valid_o, bus.wb_sel_o, bus.wb_adr_o,
                        bus.wb_dat_o}, 72'h0);
        chk("rst_rsp", {bus.rsp_status_o, bus.rsp_dat_o}, 34'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        last_st = 2'b00;
        @(negedge clk);
        chk("rdy_after_rst", bus.cmd_ready_o, 1'b1);

        // stray terminations with no cycle open
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        quiet_slave();
        chk("idle_term", {bus.rsp_valid_o, bus.wb_cyc_o}, 2'b00);

        // directed: zero-wait read, stalled write, err+ack read
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 3'b001, 32'h123, 1'b0);
        @(negedge clk);
        chk("pulse_once", {bus.rsp_valid_o, bus.wb_cyc_o}, 2'b00);
        run_txn(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 3, 0, 3'b001, 32'h55, 1'b0);
        run_txn(1'b0, 32'h10, 32'h0, 4'h3, 0, 1, 3'b101, 32'hABCD, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int ns;
            ns = $urandom_range(0, 3);
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), ns,
                    $urandom_range(0, 3), 3'($urandom_range(1, 7)), $urandom,
                    1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // back-to-back, valid held, zero-wait acks
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            run_txn(1'(i % 2), 32'(i * 4), $urandom, 4'hF, 0, 0, 3'b001,
                    32'(i + 100), 1'b1);
            if (prev >= 0) chk("b2b_gap", 32'(last_rsp_cyc - prev), 32'd2);
            prev = last_rsp_cyc;
        end

        // reset while waiting for termination
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h80;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_wait", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        last_st = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", {bus.rsp_valid_o, bus.wb_cyc_o}, 2'b00);
        end
        run_txn(1'b0, 32'h84, 32'h0, 4'hF, 1, 1, 3'b001, 32'hCAFE, 1'b0);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // ack on the deadline cycle wins
        run_txn(1'b0, 32'h90, 32'h0, 4'hF, 0, 7, 3'b001, 32'h777, 1'b0);
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        cnt = 0;
        while (bus.wb_cyc_o && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", 32'(cnt), 32'd8);
        chk("tmo_rsp", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o,
                        bus.rsp_status_o, bus.rsp_dat_o},
            {3'b001, 2'b11, 32'h0});
`else
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.wb_cyc_o && !bus.rsp_valid_o) cnt++;
            @(negedge clk);
        end
        chk("no_tmo", 32'(cnt), 32'd100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        chk("end_idle", {bus.wb_cyc_o, bus.cmd_ready_o}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning Wishbone address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning cycles with wb_cyc_o high before a transaction is aborted (range 1..65535).
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  sole clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADDR_W  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  32  read data
- rsp_status_o  out  2  00 ack, 01 err, 10 rty, 11 timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe, write enable
- wb_adr_o  out  ADDR_W  address
- wb_sel_o  out  4  byte selects
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1  slave termination and stall

Function
REQ-004 SHALL implement a pipelined Wishbone B4 master with one outstanding transaction; all outputs registered.
REQ-005 SHALL use FSM states IDLE, REQ, WAIT.
REQ-006 IDLE: cmd_ready_o=1, cyc/stb=0; on cmd_valid_i=1 SHALL latch we/adr/dat/sel onto wb_* outputs and enter REQ with wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-007 REQ: wb_stb_o held high while wb_stall_i=1; when wb_stall_i=0 SHALL drop wb_stb_o next cycle and enter WAIT unless terminated the same cycle.
REQ-008 Termination is wb_ack_i, wb_err_i or wb_rty_i sampled high in REQ with wb_stall_i=0, or in WAIT; termination in REQ while wb_stall_i=1 SHALL be ignored.
REQ-009 On termination SHALL drop wb_cyc_o and wb_stb_o, pulse rsp_valid_o for exactly one cycle, return to IDLE; cmd_ready_o high in that same cycle.
REQ-010 Simultaneous terminations SHALL prioritise err > rty > ack for rsp_status_o.
REQ-011 rsp_dat_o SHALL capture wb_dat_i on ack of a read, be 0 for writes, err, rty and timeout, and hold until the next response.
REQ-012 Minimum latency: command accepted at edge k, stb high after k, zero-wait ack sampled at k+1, rsp_valid_o high after k+1; throughput one command per 2 cycles.
REQ-013 cmd_ready_o SHALL be 0 in REQ and WAIT; cmd_valid_i ignored there.
REQ-014 Terminations while wb_cyc_o=0 SHALL be ignored.
REQ-015 wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o SHALL remain stable from command accept until termination.

Reset
REQ-016 rst_i=1 SHALL asynchronously force IDLE, cyc/stb/we/rsp_valid_o=0, cmd_ready_o=1 after release, wb_adr_o/wb_dat_o/rsp_dat_o=0, wb_sel_o=0, rsp_status_o=00, timeout counter=0.
REQ-017 Reset mid-transaction SHALL abandon it with no response pulse.

Configuration
REQ-018 With WB_CMD_MASTER_TIMEOUT_EN defined, a counter SHALL count cycles with wb_cyc_o=1, clear on each command accept, and after TIMEOUT cycles without termination abort: cyc/stb drop, rsp_valid_o pulses, rsp_status_o=11, back to IDLE.
REQ-019 A termination in the same cycle the count reaches TIMEOUT SHALL win over timeout.
REQ-020 Without WB_CMD_MASTER_TIMEOUT_EN the master SHALL wait indefinitely, status 11 never produced and the counter absent.

Verification
REQ-021 Read adr 0x4, slave ack 1 cycle after stb, wb_dat_i=0x00000123 -> one rsp_valid_o pulse, rsp_dat_o=0x00000123, status 00, wb_cyc_o low the following cycle.
REQ-022 Write adr 0x0 dat 0xDEADBEEF sel 0xF, stall held 3 cycles then ack -> stb high 4 cycles, adr/dat stable, rsp_dat_o=0, status 00.
REQ-023 Read with err and ack asserted together -> status 01, rsp_dat_o=0.
REQ-024 Macro defined, TIMEOUT=8, silent slave -> after 8 cycles cyc low, rsp_valid_o pulse, status 11; macro undefined -> cyc stays high 100 cycles.
REQ-025 rst_i pulsed in WAIT -> cyc/stb drop immediately, no rsp_valid_o, next command completes normally.
REQ-026 Back-to-back commands with cmd_valid_i held high, zero-wait ack -> one response every 2 cycles, responses matching command order.
